// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default geometry and FSM encoding.
package icache_pkg;

    localparam int ICACHE_INDEX_WIDTH_DEF = 6;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and mem_controller.
// Hits answer in one cycle; misses hold one request until mem_controller returns.
module icache
    import icache_pkg::*;
#(
    parameter int ICACHE_INDEX_WIDTH = ICACHE_INDEX_WIDTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        need_flush_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        busy_out,
    output logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        mc_valid,
    output logic [31:0] mc_addr,
    input  logic        mc_iout_ready,
    input  logic [31:0] mc_data
);

    localparam int IW      = ICACHE_INDEX_WIDTH;
    localparam int ENTRIES = 1 << IW;
    localparam int TAG_W   = 31 - IW;

    state_t state, next_state;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags  [ENTRIES];
    logic [31:0]        datas [ENTRIES];

    // Bit 0 of the pc is don't-care for 2-byte aligned fetches.
    logic [31:0]      pc_al;
    logic [31:1]      pc_lat;
    logic [IW-1:0]    fetch_idx, lat_idx;
    logic [TAG_W-1:0] fetch_tag, lat_tag;
    logic             hit, fill;

    assign pc_al     = fetch_pc & 32'hFFFF_FFFE;
    assign fetch_idx = pc_al[IW:1];
    assign fetch_tag = pc_al[31:IW+1];
    assign lat_idx   = pc_lat[IW:1];
    assign lat_tag   = pc_lat[31:IW+1];
    assign hit       = valid[fetch_idx] && (tags[fetch_idx] == fetch_tag);
    assign fill      = rdy_in && (state == WAIT_MEM) && mc_iout_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (rdy_in) begin
            if (need_flush_in) begin
                next_state = IDLE;
            end else begin
                case (state)
                    IDLE:     if (fetch_valid && !hit) next_state = WAIT_MEM;
                    WAIT_MEM: if (mc_iout_ready)       next_state = IDLE;
                    default:  next_state = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy_out = (state != IDLE);
        mc_addr  = {pc_lat, 1'b0};
    end

    // A fill lands even when a flush arrives on the same edge; only the response is dropped.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) valid <= '0;
        else if (fill) valid[lat_idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (fill && !rst_in) begin
            tags[lat_idx]  <= lat_tag;
            datas[lat_idx] <= mc_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            instr_ready <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            mc_valid    <= 1'b0;
            pc_lat      <= '0;
        end else if (rdy_in) begin
            instr_ready <= 1'b0;
            if (need_flush_in) begin
                mc_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fetch_valid) begin
                            if (hit) begin
                                instr_ready <= 1'b1;
                                instr_out   <= datas[fetch_idx];
                                instr_pc    <= pc_al;
                            end else begin
                                pc_lat   <= pc_al[31:1];
                                mc_valid <= 1'b1;
                            end
                        end
                    end
                    WAIT_MEM: begin
                        if (mc_iout_ready) begin
                            mc_valid    <= 1'b0;
                            instr_ready <= 1'b1;
                            instr_out   <= mc_data;
                            instr_pc    <= {pc_lat, 1'b0};
                        end
                    end
                    default: mc_valid <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter ICACHE_INDEX_WIDTH, default 6, log2 of the number of direct-mapped entries (64).
REQ-002 SHALL have port clk_in  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-005 SHALL have port need_flush_in  input  1  pipeline flush; cancels the outstanding fetch.
REQ-006 SHALL have port fetch_valid  input  1  fetcher requests the instruction at fetch_pc.
REQ-007 SHALL have port fetch_pc  input  32  instruction address, 2-byte aligned (bit 0 ignored).
REQ-008 SHALL have port busy_out  output  1  high when not in IDLE; fetcher requests are accepted only when low.
REQ-009 SHALL have port instr_ready  output  1  one-cycle pulse: instr_out and instr_pc are valid.
REQ-010 SHALL have port instr_out  output  32  fetched instruction; compressed forms are zero-extended 16-bit values.
REQ-011 SHALL have port instr_pc  output  32  address of instr_out.
REQ-012 SHALL have port mc_valid  output  1  instruction read request to mem_controller (its ic_valid).
REQ-013 SHALL have port mc_addr  output  32  request address (its ic_aout).
REQ-014 SHALL have port mc_iout_ready  input  1  mem_controller instruction-done pulse.
REQ-015 SHALL have port mc_data  input  32  mem_controller result, sampled only when mc_iout_ready is high.

Function
REQ-016 SHALL store per entry: valid bit, tag = pc[31:ICACHE_INDEX_WIDTH+1], data 32 bits; index = pc[ICACHE_INDEX_WIDTH:1].
REQ-017 SHALL implement states IDLE and WAIT_MEM.
REQ-018 In IDLE with fetch_valid and hit, SHALL pulse instr_ready on the next edge with the stored data and pc: hit latency 1 cycle, state stays IDLE.
REQ-019 In IDLE with fetch_valid and miss, SHALL latch pc and go to WAIT_MEM. On that same edge SHALL register mc_valid=1 and mc_addr=pc.
REQ-020 In WAIT_MEM, SHALL hold mc_valid and mc_addr constant until mc_iout_ready is sampled high, whatever arbitration delay mem_controller applies.
REQ-021 On sampling mc_iout_ready, SHALL write the entry (valid=1, tag, mc_data) and drop mc_valid. On the next edge SHALL pulse instr_ready with mc_data and the latched pc, then return to IDLE.
REQ-022 SHALL store mc_data unchanged; when mc_data[1:0]!=2'b11 the upper 16 bits are already zero and SHALL be kept zero.
REQ-023 fetch_valid while busy_out is high SHALL be ignored; the fetcher holds or re-issues it.
REQ-024 need_flush_in SHALL take priority over everything else: go to IDLE, clear mc_valid and instr_ready, and keep all entries.
REQ-025 need_flush_in together with mc_iout_ready SHALL still write the entry and SHALL NOT pulse instr_ready.
REQ-026 need_flush_in together with fetch_valid in IDLE SHALL drop the request: no instr_ready, no miss.
REQ-027 A miss to an index holding another tag SHALL overwrite that entry; no replacement state exists.
REQ-028 mc_iout_ready while in IDLE (stale) SHALL be ignored.

Reset
REQ-029 On rst_in high, independent of clk_in, SHALL set: state=IDLE, all valid bits=0, instr_ready=0, mc_valid=0, busy_out=0, instr_out=0, instr_pc=0, mc_addr=0.
REQ-030 Reset during WAIT_MEM SHALL abandon the fetch with no entry written; the tag and data arrays need no reset.

Structure
REQ-031 ICACHE_INDEX_WIDTH and the state encodings SHALL be defined in src/const_param.v alongside the existing shared constants.
REQ-032 SHALL be a single module with no sub-modules; the data and tag arrays are inferred memories and the valid bits form a resettable register vector.

Verification
REQ-033 Cold fetch of 0x00000010 with mc_data=0x00500093 returned after 5 cycles -> mc_valid asserted, mc_addr=0x10, one instr_ready with 0x00500093; the same fetch again -> instr_ready 1 cycle later, mc_valid stays 0.
REQ-034 Fetch 0x00000012 with mc_data=0x00004501 -> instr_out=0x00004501; refetch hits.
REQ-035 Fetch 0x10 then 0x90 (same index at width 6) then 0x10 -> three misses, three mc_valid requests.
REQ-036 need_flush_in 2 cycles into WAIT_MEM -> mc_valid=0 next cycle, no instr_ready; a new fetch is accepted in IDLE.
REQ-037 need_flush_in coincident with mc_iout_ready for 0x20 -> no instr_ready; a later fetch of 0x20 hits.
REQ-038 rdy_in low for 3 cycles during WAIT_MEM -> outputs frozen; on resume completes with correct data; async rst_in mid-miss -> all outputs 0 immediately, then refetch misses.
